// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: CPU-priority arbiter for the data-memory port with burst-locked loader and optional starvation guard (ARB_STARVE_GUARD_EN)
module data_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  input  logic          ldr_last,
  output logic          ldr_gnt,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);
  typedef enum logic [1:0] {IDLE = 2'd0, CPU = 2'd1, LDR = 2'd2} owner_t;
  owner_t st;
  logic force_ldr, cpu_gnt;
  assign owner = st;
  assign cpu_rdata = mem_rdata;
`ifdef ARB_STARVE_GUARD_EN
  logic [7:0] starve_cnt;
  assign force_ldr = starve_cnt == 8'(STARVE_MAX);
  // count CPU wins against a waiting loader; any loader grant clears it
  always_ff @(posedge Clk)
    if (Reset || ldr_gnt) starve_cnt <= '0;
    else if (cpu_gnt && ldr_req && !force_ldr) starve_cnt <= starve_cnt + 8'd1;
`else
  assign force_ldr = 1'b0;
`endif
  // grant and memory mux; a locked burst keeps the CPU out even if ldr_req drops
  always_comb begin
    ldr_gnt = ldr_req && (st == LDR || !cpu_req || force_ldr);
    cpu_gnt = cpu_req && st != LDR && !ldr_gnt;
    cpu_stall = cpu_req && !cpu_gnt;
    mem_addr = ldr_gnt ? ldr_addr : cpu_gnt ? cpu_addr : '0;
    mem_wdata = ldr_gnt ? ldr_wdata : cpu_gnt ? cpu_wdata : '0;
    mem_read = (ldr_gnt && !ldr_we) || (cpu_gnt && !cpu_we);
    mem_write = (ldr_gnt && ldr_we) || (cpu_gnt && cpu_we);
  end
  // ownership state and registered loader read return
  always_ff @(posedge Clk)
    if (Reset) begin
      st <= IDLE;
      ldr_rdata <= '0;
      ldr_rvalid <= 1'b0;
    end else begin
      st <= ldr_gnt ? (ldr_last ? IDLE : LDR) : cpu_gnt ? CPU : st == LDR ? LDR : IDLE;
      ldr_rvalid <= ldr_gnt && !ldr_we;
      if (ldr_gnt && !ldr_we) ldr_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed plus randomized checks of data_mem_arbiter against a burst/priority reference model
module tb_data_mem_arbiter;
  localparam int SM = 8;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic Clk = 0, Reset = 1;
  logic cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0, ldr_last = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
  logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_stall, ldr_gnt, ldr_rvalid, mem_read, mem_write;
  logic [1:0] owner;
  logic [31:0] mem [0:255];
  int checks = 0, failures = 0;
  bit locked = 0, rv = 0;
  int won = 0, own = 0, lgnt_seen = 0;
  logic [31:0] rd = 0;

  data_mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SM)) dut (
    .Clk(Clk), .Reset(Reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .ldr_req(ldr_req),
    .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_last(ldr_last),
    .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .owner(owner));

  assign mem_rdata = mem[mem_addr[7:0]];
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit cr, input bit cw_, input int ca, input logic [31:0] cd,
                     input bit lr, input bit lw_, input int la, input logic [31:0] ld, input bit ll);
    bit lg, cg;
    logic [31:0] ea, ed, crd;
    cpu_req = cr; cpu_we = cw_; cpu_addr = 32'(ca); cpu_wdata = cd;
    ldr_req = lr; ldr_we = lw_; ldr_addr = 32'(la); ldr_wdata = ld; ldr_last = ll;
    #1;
    lg = lr && (locked || !cr || (GUARD && won >= SM));
    cg = cr && !locked && !lg;
    ea = lg ? 32'(la) : cg ? 32'(ca) : 32'd0;
    ed = lg ? ld : cg ? cd : 32'd0;
    crd = mem[ca[7:0]];
    chk("ldr_gnt", 32'(ldr_gnt), 32'(lg));
    chk("cpu_stall", 32'(cpu_stall), 32'(cr && !cg));
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("mem_read", 32'(mem_read), 32'((lg && !lw_) || (cg && !cw_)));
    chk("mem_write", 32'(mem_write), 32'((lg && lw_) || (cg && cw_)));
    if (cg && !cw_) chk("cpu_rdata", cpu_rdata, crd);
    if (lg) lgnt_seen++;
    @(posedge Clk);
    rv = lg && !lw_;
    if (rv) rd = mem[la[7:0]];
    if (lg && lw_) mem[la[7:0]] = ld;
    else if (cg && cw_) mem[ca[7:0]] = cd;
    if (lg) won = 0;
    else if (cg && lr && won < SM) won++;
    own = lg ? (ll ? 0 : 2) : cg ? 1 : locked ? 2 : 0;
    locked = own == 2;
    #1;
    chk("owner", 32'(owner), 32'(own));
    chk("ldr_rvalid", 32'(ldr_rvalid), 32'(rv));
    chk("ldr_rdata", ldr_rdata, rd);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1;
    @(posedge Clk); #1;
    locked = 0; rv = 0; won = 0; own = 0; rd = 0;
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_rvalid", 32'(ldr_rvalid), 32'd0);
    chk("rst_rdata", ldr_rdata, 32'd0);
`ifdef ARB_STARVE_GUARD_EN
    chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
`endif
    @(negedge Clk);
    Reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h01010101;
    @(negedge Clk);
    do_reset();
    // CPU only: store then load
    cyc(1, 1, 'h10, 32'h1234, 0, 0, 0, 0, 0);
    cyc(1, 0, 'h10, 0, 0, 0, 0, 0, 0);
    chk("cpu_only_data", mem[8'h10], 32'h1234);
    // loader burst of four writes, CPU arrives at beat 2, then CPU granted
    cyc(0, 0, 0, 0, 1, 1, 'h20, 32'hA0, 0);
    cyc(1, 0, 'h10, 0, 1, 1, 'h24, 32'hA1, 0);
    cyc(1, 0, 'h10, 0, 1, 1, 'h28, 32'hA2, 0);
    cyc(1, 0, 'h10, 0, 1, 1, 'h2C, 32'hA3, 1);
    cyc(1, 0, 'h2C, 0, 0, 0, 0, 0, 0);
    // loader read
    mem[8'h40] = 32'hDEADBEEF;
    cyc(0, 0, 0, 0, 1, 0, 'h40, 0, 1);
    chk("ldr_read_data", ldr_rdata, 32'hDEADBEEF);
    // contention: CPU wins SM cycles, loader on cycle SM+1 only with the guard
    lgnt_seen = 0;
    for (int i = 0; i < SM + 1; i++) cyc(1, 0, i, 0, 1, 1, 'h50, 32'h55, 1);
    chk("contention_ldr_wins", 32'(lgnt_seen), GUARD ? 32'd1 : 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // lock hold: ldr_req drops mid-burst while CPU requests
    cyc(0, 0, 0, 0, 1, 1, 'h60, 32'h61, 0);
    cyc(1, 1, 'h70, 32'h77, 0, 0, 0, 0, 0);
    cyc(1, 1, 'h70, 32'h77, 0, 0, 0, 0, 0);
    cyc(1, 1, 'h70, 32'h77, 1, 1, 'h64, 32'h62, 1);
    cyc(1, 1, 'h70, 32'h77, 0, 0, 0, 0, 0);
    // reset mid-burst, CPU grantable right after
    cyc(0, 0, 0, 0, 1, 0, 'h80, 0, 0);
    ldr_addr = 32'h84;
    do_reset();
    cyc(1, 0, 'h80, 0, 0, 0, 0, 0, 0);
    // randomized traffic with bursts, contention and occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc($urandom_range(0, 2) != 0, 1'($urandom), $urandom_range(0, 255), $urandom,
               $urandom_range(0, 2) != 0, 1'($urandom), $urandom_range(0, 255), $urandom,
               $urandom_range(0, 2) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
